// File: rtl/req_ack_responder.sv
// req_ack_responder: responder side of a four-phase req/ack handshake with a sticky error flag and a transfer counter
module req_ack_responder #(
  parameter int ACK_DELAY = 2,
  parameter int MAX_HOLD  = 8,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [DATA_W-1:0] data_in,
  output logic              ack,
  output logic [DATA_W-1:0] data_out,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  xfer_cnt
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [1:0] S_DRAIN = 2'd0, S_IDLE = 2'd1, S_DELAY = 2'd2, S_ACK = 2'd3;
  logic [1:0]        state_q, state_d;
  logic [3:0]        dly_q, dly_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic              ack_q, ack_d, done_q, done_d, err_q, err_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    hold_d  = hold_q;
    ack_d   = ack_q;
    done_d  = 1'b0;
    err_d   = err_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_DRAIN: if (!req) state_d = S_IDLE;
      S_IDLE: if (req) begin
        data_d  = data_in;
        dly_d   = 4'(ACK_DELAY - 1);
        state_d = S_DELAY;
      end
      // a req drop on any delay edge, including the last, aborts so ack never rises without req
      S_DELAY: if (!req) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end else if (dly_q == 4'd0) begin
        ack_d   = 1'b1;
        hold_d  = '0;
        state_d = S_ACK;
      end else dly_d = dly_q - 4'd1;
      S_ACK: if (!req) begin
        ack_d   = 1'b0;
        done_d  = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        state_d = S_IDLE;
      end else if (hold_q == HW'(MAX_HOLD - 1)) begin
        ack_d   = 1'b0;
        err_d   = 1'b1;
        state_d = S_DRAIN;
      end else hold_d = hold_q + 1'b1;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_DRAIN;
      dly_q   <= '0;
      hold_q  <= '0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      hold_q  <= hold_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      err_q   <= err_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end
  assign ack      = ack_q;
  assign done     = done_q;
  assign err      = err_q;
  assign data_out = data_q;
  assign xfer_cnt = cnt_q;
endmodule
